term_beta_init: RTL and testbench

- Downstream consumer of the termination gamma stage.
- Collects the three termination-step gamma triples (g10 = ba1ba3, g01 = ba2, g11 = ba1ba2ba3) over a valid/ready handshake, in the order step 2, step 1, step 0.
- Performs the backward state-metric recursion over the LTE termination trellis, starting from state 0.
- Presents the eight resulting backward metrics as the beta initialisation of the last information-bit stage.

---
 rtl/term_beta_init_pkg.sv | 24 ++
 rtl/bit_clip.sv | 20 ++
 rtl/term_beta_init_step.sv | 37 +++
 rtl/term_beta_init.sv | 96 +++++++++
 tb/tb_term_beta_init.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/term_beta_init_pkg.sv
// Shared turbo-termination definitions: trellis tables, gamma selection and FSM states.
package term_beta_init_pkg;
  localparam int NUM_STATES = 8;

  typedef enum logic [1:0] {G00, G10, G01, G11} gsel_e;
  typedef enum logic {ST_ACC, ST_OUT} state_e;

  // Termination branch from s = {d1,d2,d3} always lands on s>>1
  localparam logic [2:0] TERM_NEXT [NUM_STATES] =
    '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3};

  // {x,z} emitted on that branch: x = d2^d3, z = d1^d3
  localparam logic [1:0] TERM_XZ [NUM_STATES] =
    '{2'b00, 2'b11, 2'b10, 2'b01, 2'b01, 2'b10, 2'b11, 2'b00};

  function automatic gsel_e xz_gsel(input logic [1:0] xz);
    case (xz)
      2'b10:   return G10;
      2'b01:   return G01;
      2'b11:   return G11;
      default: return G00;
    endcase
  endfunction
endpackage

// File: rtl/bit_clip.sv
// Signed width reduction with two's-complement saturation; sign-extends when widening.
module bit_clip #(
  parameter int IN_W  = 10,
  parameter int OUT_W = 7
) (
  input  logic [IN_W-1:0]  i_d,
  output logic [OUT_W-1:0] o_q
);
  if (OUT_W > IN_W) begin : g_ext
    assign o_q = {{(OUT_W-IN_W){i_d[IN_W-1]}}, i_d};
  end else if (OUT_W == IN_W) begin : g_pass
    assign o_q = i_d;
  end else begin : g_sat
    // Value fits only if every dropped bit matches the new sign bit
    logic [IN_W-OUT_W:0] w_hi;
    assign w_hi = i_d[IN_W-1:OUT_W-1];
    assign o_q  = (&w_hi || ~|w_hi) ? i_d[OUT_W-1:0]
                                    : {i_d[IN_W-1], {(OUT_W-1){~i_d[IN_W-1]}}};
  end
endmodule

// File: rtl/term_beta_init_step.sv
// One backward recursion step over the termination trellis, all states in parallel.
module term_beta_step
  import term_beta_init_pkg::*;
#(
  parameter int N = 5,
  parameter int M = 6,
  parameter int A = 10
) (
  input  logic [NUM_STATES-1:0][A-1:0] i_beta,
  input  logic [M:0]                   i_g10,
  input  logic [N-1:0]                 i_g01,
  input  logic [M:0]                   i_g11,
  output logic [NUM_STATES-1:0][A-1:0] o_beta
);
  logic [A-1:0] w_g10, w_g01, w_g11;
  logic         w_unused_hi;

  assign w_g10 = {{(A-M-1){i_g10[M]}}, i_g10};
  assign w_g01 = {{(A-N){i_g01[N-1]}}, i_g01};
  assign w_g11 = {{(A-M-1){i_g11[M]}}, i_g11};

  // s>>1 never reaches the upper half of the state space
  assign w_unused_hi = ^i_beta[NUM_STATES-1:NUM_STATES/2];

  for (genvar s = 0; s < NUM_STATES; s++) begin : g_st
    logic [A-1:0] w_gam;
    always_comb begin
      case (xz_gsel(TERM_XZ[s]))
        G10:     w_gam = w_g10;
        G01:     w_gam = w_g01;
        G11:     w_gam = w_g11;
        default: w_gam = '0;
      endcase
    end
    assign o_beta[s] = w_gam + i_beta[TERM_NEXT[s]];
  end
endmodule

// File: rtl/term_beta_init.sv
// Collects the three termination gamma triples and emits the saturated beta initialisation vector.
module term_beta_init
  import term_beta_init_pkg::*;
#(
  parameter int N = 5,
  parameter int M = 6,
  parameter int W = 7
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_flush,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic [M:0]              i_g10,
  input  logic [N-1:0]            i_g01,
  input  logic [M:0]              i_g11,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic [NUM_STATES*W-1:0] o_beta_out
);
  localparam int A = M + 4;
  localparam logic [A-1:0] NEG = {{(A-M-2){1'b1}}, {(M+2){1'b0}}};
  localparam logic [NUM_STATES-1:0][A-1:0] BETA_INIT = {{(NUM_STATES-1){NEG}}, {A{1'b0}}};

  state_e                        r_state, w_state_nx;
  logic [1:0]                    r_cnt;
  logic                          r_rdy;
  logic [NUM_STATES-1:0][A-1:0]  r_beta, w_beta_nx;
  logic [NUM_STATES-1:0][W-1:0]  r_out, w_clip;
  logic                          w_acc, w_done, w_restart;

  assign w_acc     = i_in_valid & o_in_ready;
  assign w_done    = o_out_valid & i_out_ready;
  assign w_restart = i_flush | w_done;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_ACC;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_ACC:  if (!i_flush && w_acc && r_cnt == 2'd2) w_state_nx = ST_OUT;
      ST_OUT:  if (w_restart) w_state_nx = ST_ACC;
      default: w_state_nx = ST_ACC;
    endcase
  end

  always_comb begin
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    case (r_state)
      ST_ACC:  o_in_ready  = r_rdy;
      ST_OUT:  o_out_valid = 1'b1;
      default: ;
    endcase
  end

  // r_rdy holds in_ready low until the first edge after reset release
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rdy  <= 1'b0;
      r_cnt  <= '0;
      r_beta <= BETA_INIT;
      r_out  <= '0;
    end else begin
      r_rdy <= 1'b1;
      if (w_restart) begin
        r_cnt  <= '0;
        r_beta <= BETA_INIT;
      end else if (w_acc) begin
        r_cnt  <= r_cnt + 2'd1;
        r_beta <= w_beta_nx;
        if (r_cnt == 2'd2) r_out <= w_clip;
      end
    end
  end

  term_beta_step #(.N(N), .M(M), .A(A)) u_step (
    .i_beta (r_beta),
    .i_g10  (i_g10),
    .i_g01  (i_g01),
    .i_g11  (i_g11),
    .o_beta (w_beta_nx)
  );

  for (genvar s = 0; s < NUM_STATES; s++) begin : g_clip
    bit_clip #(.IN_W(A), .OUT_W(W)) u_clip (
      .i_d (w_beta_nx[s]),
      .o_q (w_clip[s])
    );
  end

  assign o_beta_out = r_out;
endmodule

// File: tb/tb_term_beta_init.sv
// Self-checking bench for term_beta_init: directed and random blocks against a closed-form beta model.
module tb_term_beta_init;
  localparam int N = 5;
  localparam int M = 6;
  localparam int W = 7;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, out_ready;
  logic             in_ready, out_valid;
  logic [M:0]       g10, g11;
  logic [N-1:0]     g01;
  logic [8*W-1:0]   beta_out;

  int ncmp = 0;
  int nfail = 0;
  int tg10[3], tg01[3], tg11[3];   // indexed by termination step t

  term_beta_init #(.N(N), .M(M), .W(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_in_valid(in_valid),
    .o_in_ready(in_ready), .i_g10(g10), .i_g01(g01), .i_g11(g11),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_beta_out(beta_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
    ncmp++;
    assert (obs === exp_v) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Branch gamma of step t leaving state s, from x = d2^d3, z = d1^d3
  function automatic int gam(int t, int s);
    int d1 = (s >> 2) & 1;
    int d2 = (s >> 1) & 1;
    int d3 = s & 1;
    int x = d2 ^ d3;
    int z = d1 ^ d3;
    if (x == 1 && z == 0) return tg10[t];
    if (x == 0 && z == 1) return tg01[t];
    if (x == 1 && z == 1) return tg11[t];
    return 0;
  endfunction

  function automatic int ref_beta(int s);
    int v  = gam(0, s) + gam(1, s >> 1) + gam(2, s >> 2);
    int hi = (1 << (W-1)) - 1;
    int lo = -(1 << (W-1));
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  function automatic int dut_beta(int s);
    logic signed [W-1:0] b;
    b = beta_out[s*W +: W];
    return int'(b);
  endfunction

  task automatic set_all(input int a10, input int a01, input int a11);
    for (int t = 0; t < 3; t++) begin
      tg10[t] = a10; tg01[t] = a01; tg11[t] = a11;
    end
  endtask

  task automatic set_rand();
    for (int t = 0; t < 3; t++) begin
      tg10[t] = int'($urandom_range(0, 127)) - 64;
      tg01[t] = int'($urandom_range(0, 31)) - 16;
      tg11[t] = int'($urandom_range(0, 127)) - 64;
    end
  endtask

  task automatic drive(input int a10, input int a01, input int a11);
    int v;
    v = a10; g10 = v[M:0];
    v = a01; g01 = v[N-1:0];
    v = a11; g11 = v[M:0];
  endtask

  // Called at posedge+1; offers step t and returns at posedge+1 after it is taken
  task automatic feed_one(input int t);
    in_valid = 1'b1;
    drive(tg10[t], tg01[t], tg11[t]);
    @(negedge clk);
    chk($sformatf("in_ready_t%0d", t), in_ready, 1);
    chk($sformatf("ov_low_t%0d", t), out_valid, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic feed_block();
    for (int t = 2; t >= 0; t--) feed_one(t);
    chk("ov_latency", out_valid, 1);
  endtask

  task automatic check_betas(input string tag);
    for (int s = 0; s < 8; s++) chk($sformatf("%s_s%0d", tag, s), dut_beta(s), ref_beta(s));
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("ov_consumed", out_valid, 0);
    chk("ir_after_out", in_ready, 1);
  endtask

  initial begin
    int uni_exp[8];
    uni_exp = '{0, 6, 10, 8, 12, 14, 14, 8};
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(0, 0, 0);

    // Reset state
    @(posedge clk); #1;
    chk("rst_ov", out_valid, 0);
    chk("rst_ir", in_ready, 0);
    for (int s = 0; s < 8; s++) chk($sformatf("rst_beta_s%0d", s), dut_beta(s), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("ir_after_rst", in_ready, 1);

    // Uniform gammas, then back-pressure and flush with a triple offered
    set_all(4, 2, 6);
    feed_block();
    check_betas("uni");
    for (int s = 0; s < 8; s++) chk($sformatf("uni_const_s%0d", s), dut_beta(s), uni_exp[s]);
    in_valid = 1'b1; drive(-5, 3, 7);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp_ov", out_valid, 1);
      chk("bp_ir", in_ready, 0);
      check_betas("bp");
    end
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    chk("flush_ov", out_valid, 0);
    chk("flush_ir", in_ready, 1);
    set_rand();
    feed_block();
    check_betas("post_flush");
    consume();

    // Async reset while holding an output, then mid-block
    set_rand();
    feed_block();
    #2 rst = 1'b1;
    #1;
    chk("arst_ov", out_valid, 0);
    for (int s = 0; s < 8; s++) chk($sformatf("arst_beta_s%0d", s), dut_beta(s), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    set_rand();
    feed_one(2);
    rst = 1'b1;
    #1 chk("arst_mid_ir", in_ready, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("ir_after_rst2", in_ready, 1);

    // Step ordering: only the first triple is non-zero
    set_all(0, 0, 0);
    tg10[2] = 1; tg01[2] = 1; tg11[2] = 1;
    feed_block();
    check_betas("order");
    for (int s = 0; s < 8; s++) chk($sformatf("order_const_s%0d", s), dut_beta(s), (s >= 4) ? 1 : 0);
    consume();

    // Mid-block flush drops the partial accumulation
    set_rand();
    feed_one(2);
    flush = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    set_rand();
    feed_block();
    check_betas("mid_flush");
    consume();

    // Saturation at both limits
    set_all(0, 0, 63);
    feed_block();
    check_betas("satp");
    chk("satp_s6", dut_beta(6), 63);
    chk("satp_s1", dut_beta(1), 63);
    consume();
    set_all(0, 0, -64);
    feed_block();
    check_betas("satn");
    chk("satn_s6", dut_beta(6), -64);
    chk("satn_s1", dut_beta(1), -64);
    consume();

    // Back-to-back blocks with out_ready held high
    out_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      set_rand();
      feed_block();
      check_betas($sformatf("b2b%0d", b));
      @(posedge clk); #1;
      chk($sformatf("b2b%0d_ov_1cyc", b), out_valid, 0);
    end
    out_ready = 1'b0;

    // Random blocks with a random consumer delay
    for (int b = 0; b < 6; b++) begin
      set_rand();
      feed_block();
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      check_betas($sformatf("rnd%0d", b));
      consume();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
